// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder with valid/ready handshake: one full adder, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the `sub` input (a - b via stored ~b and carry-in forced to 1).

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_SUB_EN
    ,
    input  logic             sub
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s, fa_co;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    full_adder u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        accept   = in_valid && (state_q == IDLE);
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

`ifdef SERIAL_ADDER_SUB_EN
    always_comb begin
        b_load     = sub ? ~b : b;
        carry_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load     = b;
        carry_load = cin;
    end
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        if (accept) begin
            a_d     = a;
            b_d     = b_load;
            carry_d = carry_load;
            cnt_d   = '0;
            sum_d   = '0;
        end else if (state_q == RUN) begin
            // Sum fills from the MSB so bit 0 lands in sum[0] after WIDTH shifts.
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {fa_s, sum_q[WIDTH-1:1]};
            carry_d = fa_co;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
                cout_d = fa_co;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): table vectors, corner sequences, random ops.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         sub_v;

    int           vectors     = 0;
    int           miscompares = 0;
    int unsigned  cyc         = 0;
    bit           mon_en      = 1'b0;
    logic [8:0]   exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .sub       (sub_v)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        int           stall;
        bit           hold_v;
    } vec_t;

    vec_t tbl[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Reference: plain arithmetic, {cout, sum}.
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic c, input logic s);
        int r;
        if (s) begin
            r = int'(x) - int'(y);
            return {x >= y, 8'(r)};
        end
        r = int'(x) + int'(y) + int'(c);
        return 9'(r);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                         input logic [8:0] e, input int stall, input bit hold_v, input string nm);
        int lat;
        wait_idle();
        in_valid  = 1'b1;
        a         = ta;
        b         = tbv;
        cin       = tc;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = hold_v;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (lat == 0) check({nm, "_busy"}, 32'(busy), 32'd1);
            if (hold_v && lat == 3) check({nm, "_run_in_ready"}, 32'(in_ready), 32'd0);
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({nm, "_latency"}, 32'(lat), 32'd8);
        check({nm, "_result"}, 32'({cout, sum}), 32'(e));
        for (int i = 0; i < stall; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
            check({nm, "_stall_result"}, 32'({cout, sum}), 32'(e));
            check({nm, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            check({nm, "_stall_out_valid"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, "_release_in_ready"}, 32'(in_ready), 32'd1);
        check({nm, "_release_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b2b_unexpected_result: got %0h expected none", {cout, sum});
            end else begin
                check("b2b_result", 32'({cout, sum}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0]  ra, rb;
        logic        rc;
        int unsigned acc, prev;
        int          ov_seen;
        int          n;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        out_ready = 1'b0; sub_v = 1'b0;

        tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 5, 1'b0};
        tbl[1] = '{8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 0, 1'b1};
        tbl[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 2, 1'b0};
        tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0, 1'b0};
        tbl[6] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0, 1'b1};
        tbl[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 3, 1'b0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sum_cout", 32'({cout, sum}), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].co, tbl[i].s},
                  tbl[i].stall, tbl[i].hold_v, $sformatf("tbl%0d", i));
        end

        // Reset three RUN cycles into an operation.
        wait_idle();
        in_valid = 1'b1; a = 8'hC3; b = 8'h3C; cin = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sum_cout", 32'({cout, sum}), 32'd0);
        ov_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        check("midrst_no_out_valid", 32'(ov_seen), 32'd0);

        // in_valid together with rst is not accepted.
        rst = 1'b1; in_valid = 1'b1; a = 8'h11; b = 8'h22;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check("rst_blocks_accept_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("rst_blocks_accept_busy2", 32'(busy), 32'd0);
        do_op(8'h01, 8'h02, 1'b0, 9'h003, 0, 1'b0, "post_rst");

        // Back-to-back with out_ready tied high.
        wait_idle();
        mon_en = 1'b1;
        out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp_q.push_back(model(ra, rb, rc, 1'b0));
            in_valid = 1'b1; a = ra; b = rb; cin = rc;
            wait_idle();
            @(posedge clk); #1;
            acc = cyc;
            if (i > 0) check("b2b_interval", 32'(acc - prev), 32'd10);
            prev = acc;
        end
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();

`ifdef SERIAL_ADDER_SUB_EN
        sub_v = 1'b1;
        do_op(8'h10, 8'h01, 1'b0, 9'h10F, 0, 1'b0, "sub_no_borrow");
        do_op(8'h00, 8'h01, 1'b1, 9'h0FF, 1, 1'b0, "sub_borrow");
        sub_v = 1'b0;
`endif

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub_v = 1'($urandom);
`endif
            do_op(ra, rb, rc, model(ra, rb, rc, sub_v), int'($urandom_range(0, 3)),
                  1'($urandom), $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
